mem_responder: RTL and testbench

//  Memory-side responder for the multicycle CPU controller's two RAM ports.

---
 rtl/mem_pkg.sv | 13 +
 rtl/sync_ram_1rw.sv | 30 +++
 rtl/mem_responder.sv | 132 +++++++++++++
 tb/tb_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default widths for the CPU memory responder.
// Imported by the responder top and its bench.
package mem_pkg;

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_RESP, WR_ACK} mem_state_t;
    typedef enum logic {PORT_I, PORT_D} mem_port_t;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    // Wide enough for RD_LAT up to 7.
    localparam int CNT_W      = 3;

endpackage

// File: rtl/sync_ram_1rw.sv
// Single-port synchronous RAM: write-first, registered read (1-cycle latency).
// Read data holds its value until the next enabled access.
module sync_ram_1rw #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset on purpose -- contents survive rst and a
    // resettable memory would not map onto RAM macros.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata     <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency responder serving the CPU's instruction (read-only) and data
// (read/write) ports from one shared single-ported RAM, D port has priority.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_wack,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = (RD_LAT > 1) ? CNT_W'(RD_LAT - 2) : '0;

    mem_state_t        state;
    mem_port_t         owner;
    logic [CNT_W-1:0]  wait_cnt;

    logic              accepting;
    logic              rd_accept;
    mem_port_t         rd_port;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    // Ready is gated by rst so every output reads 0 while reset is held.
    always_comb begin
        accepting = ~rst & (state inside {IDLE, RD_RESP, WR_ACK});
        d_ready   = accepting & d_req;
        i_ready   = accepting & i_req & ~d_req;
        rd_accept = (d_ready & ~d_we) | i_ready;
        rd_port   = d_ready ? PORT_D : PORT_I;
        ram_en    = d_ready | i_ready;
        ram_we    = d_ready & d_we;
        ram_addr  = d_ready ? d_addr : i_addr;
    end

    sync_ram_1rw #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (d_wdata),
        .rdata (ram_rdata)
    );

    // During the rvalid cycle the RAM output is shown directly; the holding
    // register captures it at the end of that cycle.
    assign i_rdata = i_rvalid ? ram_rdata : i_rdata_q;
    assign d_rdata = d_rvalid ? ram_rdata : d_rdata_q;

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= PORT_I;
            wait_cnt  <= '0;
            i_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
            d_wack    <= 1'b0;
            busy      <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            d_wack   <= 1'b0;
            busy     <= 1'b0;

            if (i_rvalid) i_rdata_q <= ram_rdata;
            if (d_rvalid) d_rdata_q <= ram_rdata;

            case (state)
                IDLE, RD_RESP, WR_ACK: begin
                    if (d_ready && d_we) begin
                        state  <= WR_ACK;
                        d_wack <= 1'b1;
                    end else if (rd_accept) begin
                        owner <= rd_port;
                        if (RD_LAT == 1) begin
                            state    <= RD_RESP;
                            i_rvalid <= (rd_port == PORT_I);
                            d_rvalid <= (rd_port == PORT_D);
                        end else begin
                            state    <= RD_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            busy     <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end

                RD_WAIT: begin
                    if (wait_cnt == '0) begin
                        state    <= RD_RESP;
                        i_rvalid <= (owner == PORT_I);
                        d_rvalid <= (owner == PORT_D);
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                        busy     <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// scored against a word-array memory model and the fixed read-latency rule.
module tb_mem_responder;
    import mem_pkg::*;

    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_req, d_req, d_we;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          i_ready, i_rvalid, d_ready, d_rvalid, d_wack, busy;
    logic [DW-1:0] i_rdata, d_rdata;

    logic          b_i_req, b_d_req, b_d_we;
    logic [AW-1:0] b_i_addr, b_d_addr;
    logic [DW-1:0] b_d_wdata;
    logic          b_i_ready, b_i_rvalid, b_d_ready, b_d_rvalid, b_d_wack, b_busy;
    logic [DW-1:0] b_i_rdata, b_d_rdata;

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wack(d_wack), .busy(busy)
    );

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_b (
        .clk(clk), .rst(rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_ready(b_i_ready), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_ready(b_d_ready), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata), .d_wack(b_d_wack), .busy(b_busy)
    );

    logic [DW-1:0] model   [2**AW];
    logic [DW-1:0] model_b [4];
    int n_pass  = 0;
    int n_total = 0;

    task automatic check_bit(input string tag, input logic obs, input logic want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, want);
    endtask

    task automatic check_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        i_req = 1'b0;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, "_i_ready"},  i_ready,  1'b0);
        check_bit({tag, "_i_rvalid"}, i_rvalid, 1'b0);
        check_word({tag, "_i_rdata"}, i_rdata,  '0);
        check_bit({tag, "_d_ready"},  d_ready,  1'b0);
        check_bit({tag, "_d_rvalid"}, d_rvalid, 1'b0);
        check_word({tag, "_d_rdata"}, d_rdata,  '0);
        check_bit({tag, "_d_wack"},   d_wack,   1'b0);
        check_bit({tag, "_busy"},     busy,     1'b0);
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [DW-1:0] v);
        int n = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = v;
        #1;
        while (!d_ready && n < 20) begin step(); #1; n++; end
        check_bit("st_accept", d_ready, 1'b1);
        step();
        idle_a();
        #1;
        check_bit("st_wack", d_wack, 1'b1);
        check_bit("st_no_rvalid", d_rvalid, 1'b0);
        model[a] = v;
    endtask

    // A read must return model[a] exactly LAT cycles after accept, leaving the
    // other port's outputs untouched.
    task automatic do_read(input mem_port_t p, input logic [AW-1:0] a);
        logic [DW-1:0] want  = model[a];
        logic [DW-1:0] other = (p == PORT_I) ? d_rdata : i_rdata;
        int n = 0;
        if (p == PORT_I) begin i_req = 1'b1; i_addr = a; end
        else begin d_req = 1'b1; d_we = 1'b0; d_addr = a; end
        #1;
        while (!((p == PORT_I) ? i_ready : d_ready) && n < 20) begin step(); #1; n++; end
        check_bit("rd_accept", (p == PORT_I) ? i_ready : d_ready, 1'b1);
        for (int k = 1; k <= LAT; k++) begin
            step();
            if (k == 1) idle_a();
            #1;
            check_bit($sformatf("rd_valid_k%0d", k), (p == PORT_I) ? i_rvalid : d_rvalid, k == LAT);
            check_bit("rd_other_quiet", (p == PORT_I) ? d_rvalid : i_rvalid, 1'b0);
            check_bit($sformatf("rd_busy_k%0d", k), busy, k < LAT);
        end
        check_word("rd_data", (p == PORT_I) ? i_rdata : d_rdata, want);
        step();
        #1;
        check_bit("rd_pulse_end", (p == PORT_I) ? i_rvalid : d_rvalid, 1'b0);
        check_word("rd_hold", (p == PORT_I) ? i_rdata : d_rdata, want);
        check_word("rd_other_hold", (p == PORT_I) ? d_rdata : i_rdata, other);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int unsigned r = $urandom_range(0, 15);
        return (r < 8) ? AW'(r) : (11'h7F8 | AW'(r - 8));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_a();
        i_addr = '0; d_addr = '0; d_wdata = '0;
        b_i_req = 1'b0; b_d_req = 1'b0; b_d_we = 1'b0;
        b_i_addr = '0; b_d_addr = '0; b_d_wdata = '0;

        // Reset: requests held high must not be accepted.
        repeat (3) @(posedge clk);
        #1;
        i_req = 1'b1; d_req = 1'b1;
        #1;
        check_all_zero("reset");
        idle_a();
        step();
        rst = 1'b0;

        // Instruction fetch.
        do_store(11'h010, 32'hE3A0_0005);
        do_read(PORT_I, 11'h010);

        // Store then load accepted the very next cycle (write-first).
        d_req = 1'b1; d_we = 1'b1; d_addr = 11'h7FF; d_wdata = 32'hDEAD_BEEF;
        #1;
        check_bit("sl_st_ready", d_ready, 1'b1);
        step();
        d_we = 1'b0;
        #1;
        check_bit("sl_wack_t1", d_wack, 1'b1);
        check_bit("sl_ld_ready_t1", d_ready, 1'b1);
        model[11'h7FF] = 32'hDEAD_BEEF;
        step();
        idle_a();
        #1;
        check_bit("sl_rvalid_t2", d_rvalid, 1'b0);
        check_bit("sl_busy_t2", busy, 1'b1);
        step();
        #1;
        check_bit("sl_rvalid_t3", d_rvalid, 1'b1);
        check_word("sl_data_t3", d_rdata, model[11'h7FF]);
        step();
        #1;
        check_bit("sl_rvalid_t4", d_rvalid, 1'b0);

        // Contention: D wins, I accepted in D's RD_RESP cycle.
        do_store(11'h004, $urandom);
        i_req = 1'b1; i_addr = 11'h010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 11'h004;
        #1;
        check_bit("ct_d_ready_t0", d_ready, 1'b1);
        check_bit("ct_i_ready_t0", i_ready, 1'b0);
        step();
        d_req = 1'b0;
        #1;
        check_bit("ct_i_ready_t1", i_ready, 1'b0);
        step();
        #1;
        check_bit("ct_d_rvalid_t2", d_rvalid, 1'b1);
        check_word("ct_d_data_t2", d_rdata, model[11'h004]);
        check_bit("ct_i_ready_t2", i_ready, 1'b1);
        step();
        i_req = 1'b0;
        #1;
        check_bit("ct_i_rvalid_t3", i_rvalid, 1'b0);
        step();
        #1;
        check_bit("ct_i_rvalid_t4", i_rvalid, 1'b1);
        check_word("ct_i_data_t4", i_rdata, model[11'h010]);
        check_word("ct_d_hold_t4", d_rdata, model[11'h004]);
        step();

        // Reset in the middle of a read drops it.
        do_store(11'h100, $urandom);
        i_req = 1'b1; i_addr = 11'h100;
        #1;
        check_bit("mr_accept", i_ready, 1'b1);
        step();
        idle_a();
        rst = 1'b1;
        #1;
        check_all_zero("mr_rst");
        step();
        check_all_zero("mr_rst_hold");
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check_bit("mr_no_i_rvalid", i_rvalid, 1'b0);
            check_bit("mr_no_d_rvalid", d_rvalid, 1'b0);
        end
        check_word("mr_i_rdata_cleared", i_rdata, '0);
        do_read(PORT_I, 11'h100);
        do_read(PORT_I, 11'h010);

        // Back-to-back stores, one accept and one ack per cycle.
        for (int k = 0; k < 4; k++) begin
            d_req = 1'b1; d_we = 1'b1; d_addr = AW'(k); d_wdata = $urandom;
            #1;
            check_bit("bb_ready", d_ready, 1'b1);
            if (k > 0) check_bit("bb_wack", d_wack, 1'b1);
            model[k] = d_wdata;
            step();
        end
        idle_a();
        #1;
        check_bit("bb_wack_last", d_wack, 1'b1);
        for (int k = 0; k < 4; k++) do_read(PORT_D, AW'(k));

        // Random traffic over a small address pool including the top of memory.
        for (int k = 0; k < 16; k++) do_store((k < 8) ? AW'(k) : (11'h7F8 | AW'(k - 8)), $urandom);
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a = pick_addr();
            case ($urandom_range(0, 2))
                0:       do_store(a, $urandom);
                1:       do_read(PORT_D, a);
                default: do_read(PORT_I, a);
            endcase
        end

        // RD_LAT=1 instance: back-to-back stores, then fetches one per 2 cycles.
        step();
        for (int k = 0; k < 4; k++) begin
            b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = AW'(k); b_d_wdata = $urandom;
            #1;
            check_bit("b_st_ready", b_d_ready, 1'b1);
            check_bit("b_st_no_rvalid", b_d_rvalid, 1'b0);
            model_b[k] = b_d_wdata;
            step();
        end
        b_d_req = 1'b0; b_d_we = 1'b0;
        #1;
        check_bit("b_st_wack", b_d_wack, 1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            b_i_req = 1'b1; b_i_addr = AW'(k);
            #1;
            check_bit("b_rd_ready", b_i_ready, 1'b1);
            check_bit("b_rd_rvalid_low", b_i_rvalid, 1'b0);
            check_bit("b_busy_accept", b_busy, 1'b0);
            step();
            b_i_req = 1'b0;
            #1;
            check_bit("b_rd_rvalid", b_i_rvalid, 1'b1);
            check_word("b_rd_data", b_i_rdata, model_b[k]);
            check_bit("b_busy_resp", b_busy, 1'b0);
            step();
        end
        #1;
        check_bit("b_rvalid_end", b_i_rvalid, 1'b0);
        check_word("b_i_rdata_hold", b_i_rdata, model_b[3]);
        check_word("b_d_rdata_untouched", b_d_rdata, '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
